// File: rtl/sync_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// sync_fifo_wr_arb
//
// Round-robin write arbiter that shares the single upstream port of
// sync_fifo among N_REQ independent valid/ready producers. A grant is held
// in a register. The winner's stream is muxed straight through to the FIFO,
// and priority rotates after every transfer. Without the burst option that
// means after every beat; with it, after up to MAX_BURST beats.
//
// Optional feature macro: SYNC_FIFO_ARB_BURST_EN
//   When this macro is defined, a grant is kept for up to MAX_BURST
//   consecutive beats before the arbiter re-arbitrates.
//
// Parameters
//   N_REQ      number of producers (2..8)
//   DATA_W     data width, matches the FIFO word
//   MAX_BURST  beat limit per grant in the burst build (1..255)
//
// Ports
//   clk         in   rising-edge clock
//   nrst        in   asynchronous active-low reset
//   req_valid   in   [N_REQ]          per-producer valid
//   req_data    in   [N_REQ*DATA_W]   producer i at [i*DATA_W +: DATA_W]
//   req_ready   out  [N_REQ]          per-producer ready, one-hot or zero
//   fifo_valid  out                   to FIFO upstr_d_valid
//   fifo_data   out  [DATA_W]         to FIFO upstr_data
//   fifo_ready  in                    from FIFO upstr_d_ready
//   grant_vld   out                   a grant is currently held
//   grant_id    out  [clog2(N_REQ)]   current or most recent grantee
// ---------------------------------------------------------------------------
module sync_fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 33,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_valid,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_ready,
    output logic                      grant_vld,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int ID_W = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("sync_fifo_wr_arb: N_REQ must be in 2..8");
        end
        if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
            $error("sync_fifo_wr_arb: MAX_BURST must be in 1..255");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  last_q,  last_d;

    logic [DATA_W-1:0] words [N_REQ];

    logic [ID_W:0]    pick;
    logic             pick_hit;
    logic [ID_W-1:0]  pick_id;
    logic             beat;
    logic             rearb;

`ifdef SYNC_FIFO_ARB_BURST_EN
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             burst_more;
`endif

    // Unpack the flat producer bus into an indexable array so that the
    // data path stays a single N:1 mux selected by the registered grant.
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_words
            assign words[i] = req_data[i*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search starting just after 'last'. 'last' itself has the
    // lowest priority. The loop runs from the farthest candidate to the
    // nearest one, so the nearest valid requester is the one left in r.
    // The result is {hit, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  last);
        logic [ID_W:0]   r;
        logic [ID_W-1:0] sel;
        int              idx;
        r = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            sel = ID_W'(idx);
            if (v[sel]) begin
                r = {1'b1, sel};
            end
        end
        return r;
    endfunction

    assign pick     = rr_pick(req_valid, last_q);
    assign pick_hit = pick[ID_W];
    assign pick_id  = pick[ID_W-1:0];

    assign grant_vld = (state_q == GRANT);
    assign grant_id  = grant_q;
    assign beat      = grant_vld & req_valid[grant_q] & fifo_ready;

`ifdef SYNC_FIFO_ARB_BURST_EN
    assign burst_more = (int'(beat_cnt_q) + 1) < MAX_BURST;
`endif

    // Output path: purely combinational from the registered grant and the
    // live inputs. There is no path from req_valid into the grant selection.
    always_comb begin
        req_ready  = '0;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        if (grant_vld) begin
            fifo_valid = req_valid[grant_q];
            fifo_data  = words[grant_q];
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_q == ID_W'(i)) begin
                    req_ready[i] = fifo_ready;
                end
            end
        end
    end

    // Next-state logic. A finished beat re-arbitrates in the same cycle, so
    // back-to-back requesters stream with no bubble. A withdrawn request
    // drops to IDLE rather than waiting on it.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        rearb   = 1'b0;
`ifdef SYNC_FIFO_ARB_BURST_EN
        beat_cnt_d = beat_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    state_d = GRANT;
                    grant_d = pick_id;
                    last_d  = pick_id;
                end
            end
            GRANT: begin
                if (beat) begin
`ifdef SYNC_FIFO_ARB_BURST_EN
                    if (burst_more) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end else begin
                        beat_cnt_d = '0;
                        rearb      = 1'b1;
                    end
`else
                    rearb = 1'b1;
`endif
                end else if (!req_valid[grant_q]) begin
                    state_d = IDLE;
`ifdef SYNC_FIFO_ARB_BURST_EN
                    beat_cnt_d = '0;
`endif
                end
                if (rearb) begin
                    if (pick_hit) begin
                        grant_d = pick_id;
                        last_d  = pick_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant register stage. last_q resets to N_REQ-1 so producer 0 wins first.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef SYNC_FIFO_ARB_BURST_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

endmodule
